// File: rtl/base_hps_gpio_out.sv
// Avalon-MM output PIO with atomic set/clear and an optional timed pulse generator.
// Pulse logic is built only when BASE_HPS_GPIO_OUT_PULSE_EN is defined.
module base_hps_gpio_out #(
    parameter int unsigned       WIDTH       = 2,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
    parameter int unsigned       PULSE_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [2:0] A_DATA  = 3'd0;
    localparam logic [2:0] A_LEN   = 3'd1;
    localparam logic [2:0] A_START = 3'd2;
    localparam logic [2:0] A_SET   = 3'd4;
    localparam logic [2:0] A_CLR   = 3'd5;

    logic             wr;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] data_d, data_q;
    logic [31:0]      readdata_d, readdata_q;
    logic             unused_wd;

    assign wr        = chipselect & ~write_n;
    assign wd        = writedata[WIDTH-1:0];
    assign unused_wd = ^writedata;

    // Data register: plain write plus atomic set/clear.
    always_comb begin
        data_d = data_q;
        if (wr) begin
            case (address)
                A_DATA:  data_d = wd;
                A_SET:   data_d = data_q | wd;
                A_CLR:   data_d = data_q & ~wd;
                default: data_d = data_q;
            endcase
        end
    end

`ifdef BASE_HPS_GPIO_OUT_PULSE_EN
    typedef enum logic {
        S_IDLE,
        S_ACTIVE
    } state_t;

    state_t             state_d, state_q;
    logic [PULSE_W-1:0] len_d, len_q;
    logic [PULSE_W-1:0] cnt_d, cnt_q;
    logic [WIDTH-1:0]   mask_d, mask_q;
    logic               start;

    assign start = wr && (address == A_START) &&
                   (wd != '0) && (len_q != '0);

    // Pulse next-state: start/retrigger has priority over countdown.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        if (wr && address == A_LEN) begin
            len_d = writedata[PULSE_W-1:0];
        end
        if (start) begin
            mask_d  = mask_q | wd;
            cnt_d   = len_q;
            state_d = S_ACTIVE;
        end else if (state_q == S_ACTIVE) begin
            if (cnt_q == PULSE_W'(1)) begin
                mask_d  = '0;
                cnt_d   = '0;
                state_d = S_IDLE;
            end else begin
                cnt_d = cnt_q - PULSE_W'(1);
            end
        end
    end

    // Pulse FSM state and counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
        end
    end

    // Read mux, sampled every cycle regardless of chipselect.
    always_comb begin
        readdata_d = '0;
        case (address)
            A_DATA:  readdata_d = 32'(data_q);
            A_LEN:   readdata_d = 32'(len_q);
            A_START: readdata_d = 32'(mask_q);
            default: readdata_d = '0;
        endcase
    end

    assign out_port = data_q | mask_q;
`else
    // Read mux, sampled every cycle regardless of chipselect.
    always_comb begin
        readdata_d = '0;
        if (address == A_DATA) begin
            readdata_d = 32'(data_q);
        end
    end

    assign out_port = data_q;
`endif

    // Data and read-data registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q     <= RESET_VALUE;
            readdata_q <= '0;
        end else begin
            data_q     <= data_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;

endmodule

// File: tb/tb_base_hps_gpio_out.sv
// Directed bench for base_hps_gpio_out (WIDTH=2, RESET_VALUE=2'b10).
// Pulse checks are compiled in only with BASE_HPS_GPIO_OUT_PULSE_EN.
module tb_base_hps_gpio_out;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [1:0]  out_port;

    int checks = 0;
    int errors = 0;
    logic [31:0] rv;

    base_hps_gpio_out #(
        .WIDTH      (2),
        .RESET_VALUE(2'b10),
        .PULSE_W    (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // All tasks are entered at a falling edge and leave at a falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] v);
        address = a;
        @(negedge clk);
        v = readdata;
    endtask

    initial begin
        reset      = 1'b1;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        step();
        step();
        chk("rst_out", 32'(out_port), 32'h2);
        chk("rst_rd", readdata, 32'h0);
        reset = 1'b0;
        rd(3'd0, rv);
        chk("rd_data_rst", rv, 32'h2);

        wr(3'd0, 32'h3);
        chk("data3", 32'(out_port), 32'h3);
        wr(3'd5, 32'h1);
        chk("clr1", 32'(out_port), 32'h2);
        wr(3'd4, 32'h0);
        chk("set0", 32'(out_port), 32'h2);
        rd(3'd0, rv);
        chk("rd_data2", rv, 32'h2);
        wr(3'd4, 32'hFFFF_FFFD);
        chk("set_hi", 32'(out_port), 32'h3);
        wr(3'd3, 32'h0);
        chk("rsv_wr", 32'(out_port), 32'h3);
        rd(3'd4, rv);
        chk("rd_set", rv, 32'h0);
        rd(3'd3, rv);
        chk("rd_rsv", rv, 32'h0);
        address    = 3'd0;
        writedata  = 32'h0;
        chipselect = 1'b1;
        step();
        chipselect = 1'b0;
        chk("no_wstb", 32'(out_port), 32'h3);

`ifdef BASE_HPS_GPIO_OUT_PULSE_EN
        wr(3'd0, 32'h0);
        wr(3'd1, 32'h5);
        rd(3'd1, rv);
        chk("rd_len", rv, 32'h5);
        wr(3'd2, 32'h1);
        chk("p_c1", 32'(out_port), 32'h1);
        for (int i = 2; i <= 5; i++) begin
            step();
            chk($sformatf("p_c%0d", i), 32'(out_port), 32'h1);
            chk($sformatf("p_rd%0d", i), readdata, 32'h1);
        end
        step();
        chk("p_end", 32'(out_port), 32'h0);
        step();
        chk("p_rd_end", readdata, 32'h0);

        wr(3'd2, 32'h1);
        step();
        step();
        step();
        chk("rt_pre", 32'(out_port), 32'h1);
        wr(3'd2, 32'h2);
        chk("rt_c1", 32'(out_port), 32'h3);
        for (int i = 2; i <= 5; i++) begin
            step();
            chk($sformatf("rt_c%0d", i), 32'(out_port), 32'h3);
        end
        step();
        chk("rt_end", 32'(out_port), 32'h0);

        wr(3'd0, 32'h1);
        wr(3'd1, 32'h3);
        wr(3'd2, 32'h2);
        chk("pd_c1", 32'(out_port), 32'h3);
        wr(3'd1, 32'h9);
        step();
        chk("pd_c3", 32'(out_port), 32'h3);
        step();
        chk("pd_end", 32'(out_port), 32'h1);
        rd(3'd0, rv);
        chk("pd_data", rv, 32'h1);

        wr(3'd1, 32'h0);
        wr(3'd2, 32'h2);
        chk("len0", 32'(out_port), 32'h1);
        wr(3'd1, 32'h4);
        wr(3'd2, 32'h0);
        chk("mask0", 32'(out_port), 32'h1);
        rd(3'd2, rv);
        chk("mask0_rd", rv, 32'h0);

        wr(3'd0, 32'h0);
        wr(3'd2, 32'h1);
        chk("ab_on", 32'(out_port), 32'h1);
        reset = 1'b1;
        step();
        chk("ab_rst", 32'(out_port), 32'h2);
        reset = 1'b0;
        step();
        step();
        chk("ab_hold", 32'(out_port), 32'h2);
        rd(3'd1, rv);
        chk("ab_len", rv, 32'h0);
`else
        wr(3'd0, 32'h0);
        wr(3'd1, 32'h5);
        wr(3'd2, 32'h1);
        chk("np_start", 32'(out_port), 32'h0);
        step();
        chk("np_hold", 32'(out_port), 32'h0);
        rd(3'd1, rv);
        chk("np_rd1", rv, 32'h0);
        rd(3'd2, rv);
        chk("np_rd2", rv, 32'h0);
        wr(3'd0, 32'h1);
        reset = 1'b1;
        step();
        chk("np_rst", 32'(out_port), 32'h2);
        reset = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
